// File: rtl/imem_boot_loader.sv
// Streams a program image into CPU instruction memory, then enables the CPU until halt.
// Optional readback verification of the image is enabled by defining LOADER_VERIFY_EN.
module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned MAX_WORDS = 512,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_start,
  input  logic              i_halt,
  input  logic [9:0]        i_prog_len,
  input  logic              i_s_valid,
  input  logic [31:0]       i_s_data,
  output logic              o_s_ready,
  output logic [ADDR_W-1:0] o_addr_ext,
  output logic              o_wen_ext,
  output logic              o_ren_ext,
  output logic [31:0]       o_wdata_ext,
  input  logic [31:0]       i_rdata_ext,
  output logic              o_cpu_enable,
  output logic              o_busy,
  output logic              o_error
);

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StVerifyRd, StVerifyChk, StRun} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StRun} state_e;
`endif

  localparam logic [10:0] MaxWords = 11'(MAX_WORDS);

  state_e              r_state, w_state_nxt;
  logic [9:0]          r_len, w_len_nxt;
  logic [9:0]          r_cnt, w_cnt_nxt;
  logic                r_wen, w_wen_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [31:0]         r_wdata, w_wdata_nxt;
  logic                r_cpu_en, w_cpu_en_nxt;
  logic                r_error, w_error_nxt;
  logic                w_len_ok;
  logic                w_hs;
  logic [ADDR_W-1:0]   w_step;
  logic [ADDR_W-1:0]   w_cnt_addr;

`ifdef LOADER_VERIFY_EN
  logic                r_ren, w_ren_nxt;
  logic                r_ren_d1;
  logic [31:0]         r_xor_wr, w_xor_wr_nxt;
  logic [31:0]         r_xor_rd, w_xor_rd_nxt;
`else
  logic                w_unused_rdata;
  assign w_unused_rdata = ^i_rdata_ext;
`endif

  assign w_step     = ADDR_W'(ADDR_STEP);
  assign w_cnt_addr = ADDR_W'(r_cnt) * w_step;
  assign w_len_ok   = (i_prog_len != 10'd0) && ({1'b0, i_prog_len} <= MaxWords);
  assign o_s_ready  = (r_state == StLoad) && (r_cnt < r_len);
  assign w_hs       = i_s_valid && o_s_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_cnt_nxt    = r_cnt;
    w_wen_nxt    = 1'b0;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_cpu_en_nxt = r_cpu_en;
    w_error_nxt  = r_error;
`ifdef LOADER_VERIFY_EN
    w_ren_nxt    = 1'b0;
    w_xor_wr_nxt = r_xor_wr;
    // Read data returns one cycle after each issued read.
    w_xor_rd_nxt = r_ren_d1 ? (r_xor_rd ^ i_rdata_ext) : r_xor_rd;
`endif

    case (r_state)
      StIdle: begin
        if (i_start) begin
          if (w_len_ok) begin
            w_len_nxt   = i_prog_len;
            w_cnt_nxt   = 10'd0;
            w_error_nxt = 1'b0;
            w_state_nxt = StLoad;
`ifdef LOADER_VERIFY_EN
            w_xor_wr_nxt = 32'd0;
            w_xor_rd_nxt = 32'd0;
`endif
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end
      StLoad: begin
        if (w_hs) begin
          w_wen_nxt   = 1'b1;
          w_addr_nxt  = w_cnt_addr;
          w_wdata_nxt = i_s_data;
          w_cnt_nxt   = r_cnt + 10'd1;
`ifdef LOADER_VERIFY_EN
          w_xor_wr_nxt = r_xor_wr ^ i_s_data;
`endif
          if (r_cnt + 10'd1 == r_len) w_state_nxt = StDrain;
        end
      end
      StDrain: begin
`ifdef LOADER_VERIFY_EN
        // First read goes out right after the final write; counter becomes the read index.
        w_ren_nxt   = 1'b1;
        w_addr_nxt  = '0;
        w_cnt_nxt   = 10'd1;
        w_state_nxt = StVerifyRd;
`else
        w_cpu_en_nxt = 1'b1;
        w_state_nxt  = StRun;
`endif
      end
`ifdef LOADER_VERIFY_EN
      StVerifyRd: begin
        if (r_cnt < r_len) begin
          w_ren_nxt  = 1'b1;
          w_addr_nxt = w_cnt_addr;
          w_cnt_nxt  = r_cnt + 10'd1;
        end else begin
          w_state_nxt = StVerifyChk;
        end
      end
      StVerifyChk: begin
        // Wait for the last readback word to be folded in before comparing.
        if (!r_ren_d1) begin
          if (r_xor_wr == r_xor_rd) begin
            w_cpu_en_nxt = 1'b1;
            w_state_nxt  = StRun;
          end else begin
            w_error_nxt = 1'b1;
            w_state_nxt = StIdle;
          end
        end
      end
`endif
      StRun: begin
        if (i_halt) begin
          w_cpu_en_nxt = 1'b0;
          w_state_nxt  = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state  <= StIdle;
      r_len    <= 10'd0;
      r_cnt    <= 10'd0;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_cpu_en <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_len    <= w_len_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wen    <= w_wen_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_cpu_en <= w_cpu_en_nxt;
      r_error  <= w_error_nxt;
    end
  end

`ifdef LOADER_VERIFY_EN
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_ren    <= 1'b0;
      r_ren_d1 <= 1'b0;
      r_xor_wr <= 32'd0;
      r_xor_rd <= 32'd0;
    end else begin
      r_ren    <= w_ren_nxt;
      r_ren_d1 <= r_ren;
      r_xor_wr <= w_xor_wr_nxt;
      r_xor_rd <= w_xor_rd_nxt;
    end
  end
  assign o_ren_ext = r_ren;
`else
  assign o_ren_ext = 1'b0;
`endif

  assign o_addr_ext   = r_addr;
  assign o_wen_ext    = r_wen;
  assign o_wdata_ext  = r_wdata;
  assign o_cpu_enable = r_cpu_en;
  assign o_error      = r_error;
  assign o_busy       = (r_state != StIdle) && (r_state != StRun);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader with a small instruction memory model.
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        arst_n;
  logic        start, halt;
  logic [9:0]  prog_len;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [63:0] addr;
  logic        wen, ren;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        cpu_en, busy, err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [512];
  bit          corrupt = 1'b0;
  logic [63:0] ren_addr [$];
  int          overlap = 0;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .i_clk        (clk),
    .i_arst_n     (arst_n),
    .i_start      (start),
    .i_halt       (halt),
    .i_prog_len   (prog_len),
    .i_s_valid    (s_valid),
    .i_s_data     (s_data),
    .o_s_ready    (s_ready),
    .o_addr_ext   (addr),
    .o_wen_ext    (wen),
    .o_ren_ext    (ren),
    .o_wdata_ext  (wdata),
    .i_rdata_ext  (rdata),
    .o_cpu_enable (cpu_en),
    .o_busy       (busy),
    .o_error      (err)
  );

  // Instruction memory: synchronous write, read data one cycle after ren.
  always @(posedge clk) begin
    if (wen) mem[addr[10:2]] <= wdata;
    if (ren) rdata <= mem[addr[10:2]] ^ ((corrupt && addr[10:2] == 9'd1) ? 32'h1 : 32'h0);
  end

  always @(negedge clk) begin
    if (ren) ren_addr.push_back(addr);
    if (wen && ren) overlap++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_load(input logic [9:0] len);
    start    = 1'b1;
    prog_len = len;
    tick();
    start    = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [31:0] d);
    check($sformatf("ready_w%0d", idx), {63'd0, s_ready}, 64'd1);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
    check($sformatf("wen_w%0d", idx), {63'd0, wen}, 64'd1);
    check($sformatf("addr_w%0d", idx), addr, 64'(idx * 4));
    check($sformatf("wdata_w%0d", idx), {32'd0, wdata}, {32'd0, d});
  endtask

  task automatic wait_run();
    int n = 0;
    while (cpu_en !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("run_reached", {63'd0, cpu_en}, 64'd1);
    check("run_not_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_cpu_off", {63'd0, cpu_en}, 64'd0);
    check("halt_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {63'd0, s_ready}, 64'd0);
    check({tag, "_addr"}, addr, 64'd0);
    check({tag, "_wen"}, {63'd0, wen}, 64'd0);
    check({tag, "_ren"}, {63'd0, ren}, 64'd0);
    check({tag, "_wdata"}, {32'd0, wdata}, 64'd0);
    check({tag, "_cpu"}, {63'd0, cpu_en}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    arst_n = 1'b0; start = 1'b0; halt = 1'b0; prog_len = 10'd0;
    s_valid = 1'b0; s_data = 32'd0;
    repeat (2) tick();
    check_all_zero("rst");
    arst_n = 1'b1;
    tick();
    check_all_zero("post_rst");

    // Three words back to back, then RUN.
    start_load(10'd3);
    check("load_busy", {63'd0, busy}, 64'd1);
    send_word(0, 32'h0050_0093);
    send_word(1, 32'h00A0_0113);
    send_word(2, 32'h0020_81B3);
    check("drain_ready", {63'd0, s_ready}, 64'd0);
    check("drain_cpu", {63'd0, cpu_en}, 64'd0);
`ifndef LOADER_VERIFY_EN
    tick();
    check("run_2cyc_cpu", {63'd0, cpu_en}, 64'd1);
    check("run_wen_off", {63'd0, wen}, 64'd0);
`endif
    wait_run();
    check("halt_ignored_start", {63'd0, s_ready}, 64'd0);
    do_halt();

    // Four words with a two-cycle gap; a stray start during the gap is ignored.
    start_load(10'd4);
    send_word(0, 32'h1111_0001);
    s_valid  = 1'b0;
    start    = 1'b1;
    prog_len = 10'd1;
    tick();
    start    = 1'b0;
    check("gap1_ready", {63'd0, s_ready}, 64'd1);
    check("gap1_wen", {63'd0, wen}, 64'd0);
    tick();
    check("gap2_ready", {63'd0, s_ready}, 64'd1);
    check("gap2_wen", {63'd0, wen}, 64'd0);
    send_word(1, 32'h2222_0002);
    send_word(2, 32'h3333_0003);
    send_word(3, 32'h4444_0004);
    wait_run();
    do_halt();

    // Illegal lengths.
    start_load(10'd0);
    check("len0_err", {63'd0, err}, 64'd1);
    check("len0_busy", {63'd0, busy}, 64'd0);
    check("len0_ready", {63'd0, s_ready}, 64'd0);
    check("len0_wen", {63'd0, wen}, 64'd0);
    start_load(10'd600);
    check("len600_err", {63'd0, err}, 64'd1);
    check("len600_busy", {63'd0, busy}, 64'd0);
    check("len600_ready", {63'd0, s_ready}, 64'd0);
    check("len600_wen", {63'd0, wen}, 64'd0);
    start_load(10'd1);
    check("restart_err_clr", {63'd0, err}, 64'd0);
    send_word(0, 32'hCAFE_0001);
    wait_run();
    do_halt();

    // Asynchronous reset after two of five words.
    start_load(10'd5);
    send_word(0, 32'hA000_0000);
    send_word(1, 32'hA000_0001);
    arst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    arst_n = 1'b1;
    tick();
    start_load(10'd5);
    for (int i = 0; i < 5; i++) send_word(i, 32'hB000_0000 + 32'(i));
    wait_run();
    do_halt();

`ifdef LOADER_VERIFY_EN
    // Corrupted readback of word 1 must block the CPU.
    ren_addr.delete();
    corrupt = 1'b1;
    start_load(10'd2);
    send_word(0, 32'h1234_5678);
    send_word(1, 32'h9ABC_DEF0);
    begin
      int n = 0;
      while (busy === 1'b1 && n < 30) begin
        tick();
        n++;
      end
    end
    check("vfy_bad_busy", {63'd0, busy}, 64'd0);
    check("vfy_bad_err", {63'd0, err}, 64'd1);
    check("vfy_bad_cpu", {63'd0, cpu_en}, 64'd0);
    check("vfy_bad_nreads", 64'(ren_addr.size()), 64'd2);
    if (ren_addr.size() == 2) begin
      check("vfy_rd0_addr", ren_addr[0], 64'h0);
      check("vfy_rd1_addr", ren_addr[1], 64'h4);
    end
    corrupt = 1'b0;
    start_load(10'd2);
    send_word(0, 32'h1234_5678);
    send_word(1, 32'h9ABC_DEF0);
    wait_run();
    check("vfy_good_err", {63'd0, err}, 64'd0);
    do_halt();
`else
    check("no_reads", 64'(ren_addr.size()), 64'd0);
`endif
    check("no_wen_ren_overlap", 64'(overlap), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
